// File: rtl/add_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Defaults match the standard 4-requester, 32-bit, single-cycle adder build.
package add_sched_pkg;

    localparam int DEF_N    = 4;
    localparam int DEF_W    = 32;
    localparam int DEF_LAT  = 1;
    localparam int ID_MAX_W = 4;

    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    // First set request at or after ptr, wrapping modulo n; vld=0 if none.
    function automatic tag_t rr_winner(input logic [15:0] req,
                                       input logic [ID_MAX_W-1:0] ptr,
                                       input int n);
        tag_t res;
        int   idx;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !res.vld && req[idx[3:0]]) begin
                res.vld = 1'b1;
                res.id  = idx[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a rotating priority pointer.
// The pointer moves past the winner only when the grant is accepted.
module rr_arbiter import add_sched_pkg::*; #(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic [N-1:0]   req_i,
    input  logic           accept_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_id_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [15:0]    req_ext;
    tag_t           win;
    logic           unused_win;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req_i;
        win              = rr_winner(req_ext, ID_MAX_W'(ptr_q), N);
        grant_id_o       = win.id[IDW-1:0];
        grant_o          = '0;
        if (en_i && win.vld) grant_o[grant_id_o] = 1'b1;
        ptr_d = ptr_q;
        if (accept_i) ptr_d = (int'(grant_id_o) == N-1) ? '0 : grant_id_o + 1'b1;
    end

    assign unused_win = ^win.id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/add_sched.sv
// Shares one registered adder among N requesters: round-robin issue,
// operand registers, and a tag pipeline that labels each returning sum.
module add_sched import add_sched_pkg::*; #(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int LAT = DEF_LAT,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_out,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic [31:0]    issue_cnt
);

    logic [IDW-1:0] gid;
    logic           hs;
    logic [W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
    tag_t           tag_q [LAT+1];
    tag_t           tag0_d;
    logic [31:0]    issue_cnt_q, issue_cnt_d;
    logic           unused_tag;

    // Gating with rst_n keeps grants off while reset is held.
    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en & rst_n),
        .req_i      (req_valid),
        .accept_i   (hs),
        .grant_o    (req_ready),
        .grant_id_o (gid)
    );

    assign hs = |(req_valid & req_ready);

    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        tag0_d      = '0;
        issue_cnt_d = issue_cnt_q;
        if (hs) begin
            add_a_d     = req_a[gid*W +: W];
            add_b_d     = req_b[gid*W +: W];
            tag0_d.vld  = 1'b1;
            tag0_d.id   = ID_MAX_W'(gid);
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            issue_cnt_q <= '0;
            for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            issue_cnt_q <= issue_cnt_d;
            tag_q[0]    <= tag0_d;
            for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    // Final tag stage lines up with the adder's registered result.
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign issue_cnt  = issue_cnt_q;
    assign rsp_valid  = tag_q[LAT].vld;
    assign rsp_id     = tag_q[LAT].id[IDW-1:0];
    assign rsp_data   = add_out;
    assign unused_tag = ^tag_q[LAT].id;

endmodule
